// File: rtl/pong_match_ctrl.sv
// ============================================================================
// pong_match_ctrl : Pong match/score sequencer (idle, serve, rally, point, over)
// Optional win-by-two deuce rule: define PONG_WIN_BY_TWO_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module pong_match_ctrl #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int FRAME_CNT_W  = 8
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               goal1,
   input  logic               goal2,
   output logic [SCORE_W-1:0] player1_score,
   output logic [SCORE_W-1:0] player2_score,
   output logic               ball_run,
   output logic               serve_dir,
   output logic               game_over,
   output logic               winner
);

   generate
      if (WIN_SCORE + 1 > 2**SCORE_W - 1) begin : g_chk_win_score
         $error("pong_match_ctrl: WIN_SCORE+1 exceeds max score 2**SCORE_W-1");
      end
      if (SERVE_FRAMES >= 2**FRAME_CNT_W) begin : g_chk_serve_frames
         $error("pong_match_ctrl: SERVE_FRAMES does not fit in FRAME_CNT_W");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [SCORE_W-1:0]     SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0]     SCORE_ONE = SCORE_W'(1);
   localparam logic [SCORE_W:0]       WIN_X     = (SCORE_W+1)'(WIN_SCORE);
   localparam logic [FRAME_CNT_W-1:0] CNT_LOAD  = FRAME_CNT_W'(SERVE_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] CNT_ONE   = FRAME_CNT_W'(1);

   state_t                 state_q, state_d;
   logic [SCORE_W-1:0]     p1_score_q, p1_score_d;
   logic [SCORE_W-1:0]     p2_score_q, p2_score_d;
   logic [FRAME_CNT_W-1:0] count_q, count_d;
   logic                   serve_dir_q, serve_dir_d;
   logic                   winner_q, winner_d;
   logic                   start_q, start_d;
   logic                   last_p1_q, last_p1_d;

   logic                   start_rise;
   logic [SCORE_W:0]       p1_x, p2_x;
   logic                   win;
   logic                   p2_lead;

   assign start_rise = start & ~start_q;
   assign p1_x       = {1'b0, p1_score_q};
   assign p2_x       = {1'b0, p2_score_q};
   assign p2_lead    = (p2_score_q > p1_score_q);

`ifdef PONG_WIN_BY_TWO_EN
   localparam logic [SCORE_W:0]   TWO_X = (SCORE_W+1)'(2);
   localparam logic [SCORE_W-1:0] DEUCE = SCORE_W'(WIN_SCORE - 1);
   logic deuce;
   // Scores never exceed WIN_SCORE+1, so the extended sums cannot overflow.
   assign win   = ((p1_x >= WIN_X) && (p1_x >= p2_x + TWO_X)) ||
                  ((p2_x >= WIN_X) && (p2_x >= p1_x + TWO_X));
   assign deuce = (p1_score_q == p2_score_q) && (p1_score_q >= DEUCE);
`else
   assign win = (p1_x >= WIN_X) || (p2_x >= WIN_X);
`endif

   always_comb begin
      state_d     = state_q;
      p1_score_d  = p1_score_q;
      p2_score_d  = p2_score_q;
      count_d     = count_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      last_p1_d   = last_p1_q;
      start_d     = start;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_rise) begin
               state_d    = ST_SERVE;
               p1_score_d = '0;
               p2_score_d = '0;
               count_d    = CNT_LOAD;
            end
         end
         ST_SERVE: begin
            if (count_q == '0) begin
               state_d = ST_PLAY;
            end else if (frame_tick) begin
               count_d = count_q - CNT_ONE;
            end
         end
         ST_PLAY: begin
            // Simultaneous goals are treated as a collision glitch.
            if (goal1 ^ goal2) begin
               state_d   = ST_POINT;
               last_p1_d = goal1;
               if (goal1) begin
                  p1_score_d = (p1_score_q == SCORE_MAX) ? p1_score_q : p1_score_q + SCORE_ONE;
               end else begin
                  p2_score_d = (p2_score_q == SCORE_MAX) ? p2_score_q : p2_score_q + SCORE_ONE;
               end
            end
         end
         ST_POINT: begin
            if (win) begin
               state_d  = ST_OVER;
               winner_d = p2_lead;
            end else begin
               state_d     = ST_SERVE;
               count_d     = CNT_LOAD;
               serve_dir_d = last_p1_q;
`ifdef PONG_WIN_BY_TWO_EN
               if (deuce) begin
                  p1_score_d = DEUCE;
                  p2_score_d = DEUCE;
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         p1_score_q  <= '0;
         p2_score_q  <= '0;
         count_q     <= '0;
         serve_dir_q <= 1'b0;
         winner_q    <= 1'b0;
         start_q     <= 1'b0;
         last_p1_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         p1_score_q  <= p1_score_d;
         p2_score_q  <= p2_score_d;
         count_q     <= count_d;
         serve_dir_q <= serve_dir_d;
         winner_q    <= winner_d;
         start_q     <= start_d;
         last_p1_q   <= last_p1_d;
      end
   end

   assign player1_score = p1_score_q;
   assign player2_score = p2_score_q;
   assign ball_run      = (state_q == ST_PLAY);
   assign game_over     = (state_q == ST_OVER);
   assign serve_dir     = serve_dir_q;
   assign winner        = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl (SERVE_FRAMES=3, WIN_SCORE=3).
`default_nettype none

module tb_pong_match_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       goal1 = 1'b0;
   logic       goal2 = 1'b0;
   logic [3:0] p1, p2;
   logic       ball_run, serve_dir, game_over, winner;

   int checks = 0;
   int errors = 0;

   pong_match_ctrl #(
      .SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(3), .FRAME_CNT_W(8)
   ) dut (
      .clk_100MHz   (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .start        (start),
      .goal1        (goal1),
      .goal2        (goal2),
      .player1_score(p1),
      .player2_score(p2),
      .ball_run     (ball_run),
      .serve_dir    (serve_dir),
      .game_over    (game_over),
      .winner       (winner)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Three frame ticks with gaps; the gap after the third lands in PLAY.
   task automatic frames_to_play();
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   task automatic goal(input logic g1, input logic g2);
      goal1 = g1; goal2 = g2; step();
      goal1 = 1'b0; goal2 = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step();
      start = 1'b0;
   endtask

   // Non-winning point followed by the full serve back to PLAY.
   task automatic rally_point(input logic p1_scores);
      goal(p1_scores, !p1_scores);
      step();
      frames_to_play();
   endtask

   task automatic test_reset();
      step(); step();
      checks++;
      if ({p1, p2, ball_run, serve_dir, game_over, winner} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got p1=%0d p2=%0d run=%b dir=%b over=%b win=%b, need all 0",
                  p1, p2, ball_run, serve_dir, game_over, winner);
      end
      reset = 1'b0;
      step();
      checks++;
      if (ball_run !== 1'b0) begin
         errors++; $display("FAIL idle_no_run: ball_run=%b need 0", ball_run);
      end
   endtask

   task automatic test_serve();
      pulse_start();
      checks++;
      if (ball_run !== 1'b0 || p1 !== 4'd0 || p2 !== 4'd0) begin
         errors++; $display("FAIL serve_entry: run=%b p1=%0d p2=%0d need 0/0/0", ball_run, p1, p2);
      end
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      checks++;
      if (ball_run !== 1'b0) begin
         errors++; $display("FAIL serve_third_tick: ball_run=%b need 0", ball_run);
      end
      step();
      checks++;
      if (ball_run !== 1'b1) begin
         errors++; $display("FAIL serve_to_play: ball_run=%b need 1", ball_run);
      end
   endtask

   task automatic test_goal();
      goal(1'b1, 1'b0);
      checks++;
      if (p1 !== 4'd1 || p2 !== 4'd0 || ball_run !== 1'b0) begin
         errors++; $display("FAIL goal1_update: p1=%0d p2=%0d run=%b need 1/0/0", p1, p2, ball_run);
      end
      step();
      checks++;
      if (serve_dir !== 1'b1 || game_over !== 1'b0) begin
         errors++; $display("FAIL point_serve_dir: dir=%b over=%b need 1/0", serve_dir, game_over);
      end
      frames_to_play();
      checks++;
      if (ball_run !== 1'b1) begin
         errors++; $display("FAIL reserve_to_play: ball_run=%b need 1", ball_run);
      end
   endtask

   task automatic test_glitch();
      goal(1'b1, 1'b1);
      checks++;
      if (p1 !== 4'd1 || p2 !== 4'd0 || ball_run !== 1'b1) begin
         errors++; $display("FAIL double_goal: p1=%0d p2=%0d run=%b need 1/0/1", p1, p2, ball_run);
      end
      goal(1'b0, 1'b1);
      step();
      checks++;
      if (p2 !== 4'd1 || serve_dir !== 1'b0) begin
         errors++; $display("FAIL goal2_serve_dir: p2=%0d dir=%b need 1/0", p2, serve_dir);
      end
      goal(1'b1, 1'b0);
      step();
      checks++;
      if (p1 !== 4'd1 || ball_run !== 1'b0) begin
         errors++; $display("FAIL goal_in_serve: p1=%0d run=%b need 1/0", p1, ball_run);
      end
      frames_to_play();
   endtask

   task automatic test_reset_mid_play();
      rally_point(1'b1);
      checks++;
      if (p1 !== 4'd2 || p2 !== 4'd1 || ball_run !== 1'b1 || serve_dir !== 1'b1) begin
         errors++; $display("FAIL pre_reset_state: p1=%0d p2=%0d run=%b dir=%b need 2/1/1/1",
                            p1, p2, ball_run, serve_dir);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({p1, p2, ball_run, serve_dir, game_over, winner} !== 12'h000) begin
         errors++; $display("FAIL async_reset: p1=%0d p2=%0d run=%b dir=%b need all 0",
                            p1, p2, ball_run, serve_dir);
      end
      @(negedge clk);
      reset = 1'b0;
      frames_to_play();
      checks++;
      if (ball_run !== 1'b0 || p1 !== 4'd0) begin
         errors++; $display("FAIL idle_after_reset: run=%b p1=%0d need 0/0", ball_run, p1);
      end
   endtask

   task automatic test_win();
      pulse_start();
      frames_to_play();
      rally_point(1'b0);
      rally_point(1'b0);
      goal(1'b0, 1'b1);
      checks++;
      if (p2 !== 4'd3 || game_over !== 1'b0) begin
         errors++; $display("FAIL win_score_edge: p2=%0d over=%b need 3/0", p2, game_over);
      end
      step();
      checks++;
      if (game_over !== 1'b1 || winner !== 1'b1 || p1 !== 4'd0 || p2 !== 4'd3 || ball_run !== 1'b0) begin
         errors++; $display("FAIL game_over: over=%b win=%b p1=%0d p2=%0d run=%b need 1/1/0/3/0",
                            game_over, winner, p1, p2, ball_run);
      end
      goal(1'b1, 1'b0);
      step();
      checks++;
      if (p1 !== 4'd0 || p2 !== 4'd3 || game_over !== 1'b1) begin
         errors++; $display("FAIL over_hold: p1=%0d p2=%0d over=%b need 0/3/1", p1, p2, game_over);
      end
      pulse_start();
      checks++;
      if (p1 !== 4'd0 || p2 !== 4'd0 || game_over !== 1'b0 || ball_run !== 1'b0) begin
         errors++; $display("FAIL restart: p1=%0d p2=%0d over=%b run=%b need 0/0/0/0",
                            p1, p2, game_over, ball_run);
      end
      frames_to_play();
      checks++;
      if (ball_run !== 1'b1) begin
         errors++; $display("FAIL restart_play: ball_run=%b need 1", ball_run);
      end
   endtask

`ifdef PONG_WIN_BY_TWO_EN
   task automatic test_deuce();
      rally_point(1'b1);
      rally_point(1'b0);
      rally_point(1'b1);
      rally_point(1'b0);
      rally_point(1'b1);
      checks++;
      if (p1 !== 4'd3 || p2 !== 4'd2 || game_over !== 1'b0) begin
         errors++; $display("FAIL adv_no_win: p1=%0d p2=%0d over=%b need 3/2/0", p1, p2, game_over);
      end
      goal(1'b0, 1'b1);
      checks++;
      if (p1 !== 4'd3 || p2 !== 4'd3) begin
         errors++; $display("FAIL tie_three: p1=%0d p2=%0d need 3/3", p1, p2);
      end
      step();
      checks++;
      if (p1 !== 4'd2 || p2 !== 4'd2 || game_over !== 1'b0) begin
         errors++; $display("FAIL deuce_reset: p1=%0d p2=%0d over=%b need 2/2/0", p1, p2, game_over);
      end
      frames_to_play();
      rally_point(1'b1);
      goal(1'b1, 1'b0);
      step();
      checks++;
      if (game_over !== 1'b1 || winner !== 1'b0 || p1 !== 4'd4 || p2 !== 4'd2) begin
         errors++; $display("FAIL deuce_win: over=%b win=%b p1=%0d p2=%0d need 1/0/4/2",
                            game_over, winner, p1, p2);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_serve();
      test_goal();
      test_glitch();
      test_reset_mid_play();
      test_win();
`ifdef PONG_WIN_BY_TWO_EN
      test_deuce();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
